// File: rtl/seq_alu_unit.sv
// seq_alu_unit: multi-cycle ALU with start/done handshake, radix-2 Booth multiply
// and signed non-restoring divide, one bit per cycle; result is {HI,LO}.
module seq_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   reg_a,
  input  logic [WIDTH-1:0]   reg_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  localparam logic [4:0] OP_SHL  = 5'b00001;
  localparam logic [4:0] OP_SHR  = 5'b00010;
  localparam logic [4:0] OP_SHRA = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b00100;
  localparam logic [4:0] OP_ROR  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_NEG  = 5'b01001;
  localparam logic [4:0] OP_ADD  = 5'b01010;
  localparam logic [4:0] OP_SUB  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  state_t state, nxt;

  logic [4:0]           op;
  logic [WIDTH-1:0]     a, b, q, d;
  logic [WIDTH:0]       r;
  logic [2*WIDTH+1:0]   acc;
  logic [SHW-1:0]       cnt;
  logic                 neg_q, neg_r;
  logic                 accept, last;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last   = cnt == LAST;
  assign busy   = state != S_IDLE && state != S_DONE;
  assign done   = state == S_DONE;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: nxt = !start ? S_IDLE :
                            opcode == OP_MUL ? S_MUL :
                            (opcode == OP_DIV && reg_b != '0) ? S_DIV : S_EXEC;
      S_EXEC:         nxt = S_DONE;
      S_MUL:          nxt = last ? S_DONE : S_MUL;
      S_DIV:          nxt = last ? S_FIX : S_DIV;
      S_FIX:          nxt = S_DONE;
      default:        nxt = S_IDLE;
    endcase
  end

  // Booth step: acc = {partial HI (WIDTH+1, sign guard), multiplier, q[-1]}
  logic [WIDTH:0]     m_ext, hi, hi_n;
  logic [2*WIDTH+1:0] acc_n;
  assign m_ext = {a[WIDTH-1], a};
  assign hi    = acc[2*WIDTH+1:WIDTH+1];
  assign hi_n  = acc[1:0] == 2'b01 ? hi + m_ext :
                 acc[1:0] == 2'b10 ? hi - m_ext : hi;
  assign acc_n = {hi_n[WIDTH], hi_n, acc[WIDTH:1]};

  // non-restoring step on magnitudes; signs are applied in FIX
  logic [WIDTH:0]   r_sh, r_n;
  logic [WIDTH-1:0] q_n, rem, quo, rmd;
  assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
  assign r_n  = r[WIDTH] ? r_sh + {1'b0, d} : r_sh - {1'b0, d};
  assign q_n  = {q[WIDTH-2:0], ~r_n[WIDTH]};
  assign rem  = r[WIDTH-1:0] + (r[WIDTH] ? d : '0);
  assign quo  = neg_q ? -q : q;
  assign rmd  = neg_r ? -rem : rem;

  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   lo;
  logic               ext;
  logic [2*WIDTH-1:0] exec_res;
  assign sh = b[SHW-1:0];

  always_comb begin
    lo = '0;
    case (op)
      OP_SHL:  lo = a << sh;
      OP_SHR:  lo = a >> sh;
      OP_SHRA: lo = $signed(a) >>> sh;
      OP_ROL:  lo = WIDTH'(({a, a} << sh) >> WIDTH);
      OP_ROR:  lo = WIDTH'({a, a} >> sh);
      OP_AND:  lo = a & b;
      OP_OR:   lo = a | b;
      OP_NOT:  lo = ~a;
      OP_NEG:  lo = -a;
      OP_ADD:  lo = a + b;
      OP_SUB:  lo = a - b;
      default: lo = '0;
    endcase
  end

  assign ext      = op == OP_NEG || op == OP_ADD || op == OP_SUB;
  assign exec_res = ext ? {{WIDTH{lo[WIDTH-1]}}, lo} : {{WIDTH{1'b0}}, lo};

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= S_IDLE;
      result   <= '0;
      div_zero <= 1'b0;
      op       <= '0;
      a        <= '0;
      b        <= '0;
      q        <= '0;
      d        <= '0;
      r        <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE, S_DONE: if (accept) begin
          op       <= opcode;
          a        <= reg_a;
          b        <= reg_b;
          cnt      <= '0;
          div_zero <= 1'b0;
          acc      <= {{(WIDTH+1){1'b0}}, reg_b, 1'b0};
          r        <= '0;
          q        <= reg_a[WIDTH-1] ? -reg_a : reg_a;
          d        <= reg_b[WIDTH-1] ? -reg_b : reg_b;
          neg_q    <= reg_a[WIDTH-1] ^ reg_b[WIDTH-1];
          neg_r    <= reg_a[WIDTH-1];
        end
        S_EXEC: begin
          result   <= exec_res;
          div_zero <= op == OP_DIV;
        end
        S_MUL: begin
          acc <= acc_n;
          cnt <= cnt + 1'b1;
          if (last) result <= acc_n[2*WIDTH:1];
        end
        S_DIV: begin
          r   <= r_n;
          q   <= q_n;
          cnt <= cnt + 1'b1;
        end
        S_FIX: result <= {rmd, quo};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit: directed and randomized checks of seq_alu_unit against a
// plain-arithmetic reference model.
module tb_seq_alu_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          clr, start;
  logic [4:0]    opcode;
  logic [W-1:0]  reg_a, reg_b;
  logic          busy, done, div_zero;
  logic [2*W-1:0] result;
  int n_tests = 0;
  int n_fail  = 0;

  seq_alu_unit #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode),
    .reg_a(reg_a), .reg_b(reg_b), .busy(busy), .done(done),
    .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] res, output logic dz, output int lat);
    longint sa, sb, p, t;
    logic [31:0] lo;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    lo = '0;
    res = '0;
    dz = 1'b0;
    lat = 1;
    case (op)
      5'd1:  lo = a << sh;
      5'd2:  lo = a >> sh;
      5'd3:  begin t = sa >>> sh; lo = t[31:0]; end
      5'd4:  lo = (a << sh) | (sh == 0 ? 32'd0 : a >> (32 - sh));
      5'd5:  lo = (a >> sh) | (sh == 0 ? 32'd0 : a << (32 - sh));
      5'd6:  lo = a & b;
      5'd7:  lo = a | b;
      5'd8:  lo = ~a;
      5'd9:  lo = -a;
      5'd10: lo = a + b;
      5'd11: lo = a - b;
      5'd12: begin p = sa * sb; res = p; lat = 32; end
      5'd13: if (b == 0) dz = 1'b1;
             else begin
               p = sa / sb;
               t = sa % sb;
               res = {t[31:0], p[31:0]};
               lat = 33;
             end
      default: ;
    endcase
    if (op >= 5'd1 && op <= 5'd8) res = {32'd0, lo};
    if (op >= 5'd9 && op <= 5'd11) res = {{32{lo[31]}}, lo};
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [63:0] er;
    logic edz;
    int elat, lat;
    model(op, a, b, er, edz, elat);
    @(negedge clk);
    start = 1'b1; opcode = op; reg_a = a; reg_b = b;
    @(negedge clk);
    start = 1'b0; opcode = 5'($urandom); reg_a = $urandom; reg_b = $urandom;
    check($sformatf("op%0d busy_after_start", op), {63'd0, busy}, 64'd1);
    lat = 0;
    while (!done && lat < 100) begin
      start = noise && lat < elat && $urandom_range(0, 1) == 1;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check($sformatf("op%0d latency", op), 64'(lat), 64'(elat));
    check($sformatf("op%0d a=%h b=%h result", op, a, b), result, er);
    check($sformatf("op%0d div_zero", op), {63'd0, div_zero}, {63'd0, edz});
    check($sformatf("op%0d busy_at_done", op), {63'd0, busy}, 64'd0);
    @(negedge clk);
    check($sformatf("op%0d done_single", op), {63'd0, done}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      4: v = 32'h7FFFFFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int cnt;
    logic [4:0] op;
    clr = 1'b0; start = 1'b0; opcode = '0; reg_a = '0; reg_b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset result", result, 64'd0);
    check("reset div_zero", {63'd0, div_zero}, 64'd0);
    clr = 1'b1;

    // abort a multiply with reset
    @(negedge clk);
    start = 1'b1; opcode = 5'd12; reg_a = 32'd7; reg_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("abort result", result, 64'd0);
    clr = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort no_done", 64'(cnt), 64'd0);
    run_op(5'd10, 32'd5, 32'hFFFFFFF8, 1'b0);
    check("add_5_m8", result, 64'hFFFFFFFF_FFFFFFFD);

    run_op(5'd12, 32'hFFFFFFFA, 32'd7, 1'b1);
    check("mul_m6_7", result, 64'hFFFFFFFF_FFFFFFD6);
    run_op(5'd13, 32'hFFFFFFEF, 32'd5, 1'b1);
    check("div_m17_5", result, 64'hFFFFFFFE_FFFFFFFD);
    run_op(5'd13, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_min_m1", result, 64'h00000000_80000000);
    run_op(5'd13, 32'd9, 32'd0, 1'b0);
    check("div_by_zero flag", {63'd0, div_zero}, 64'd1);
    run_op(5'd3, 32'h80000000, 32'd33, 1'b0);
    check("shra_after_dz", result, 64'h00000000_C0000000);
    run_op(5'b10101, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    run_op(5'd9, 32'h80000000, 32'd0, 1'b0);
    check("neg_min", result, 64'hFFFFFFFF_80000000);
    run_op(5'd12, 32'h80000000, 32'h80000000, 1'b0);
    run_op(5'd4, 32'h80000001, 32'hFFFFFFE0, 1'b0);

    // back-to-back: start held high across DONE
    @(negedge clk);
    start = 1'b1; opcode = 5'd5; reg_a = 32'h1; reg_b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b ror_result", result, 64'h00000000_80000000);
    start = 1'b1; opcode = 5'd7; reg_a = 32'hF0; reg_b = 32'h0F;
    @(negedge clk);
    start = 1'b0;
    check("b2b gap_done", {63'd0, done}, 64'd0);
    check("b2b gap_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("b2b or_done", {63'd0, done}, 64'd1);
    check("b2b or_result", result, 64'h00000000_000000FF);
    @(negedge clk);
    check("b2b or_done_single", {63'd0, done}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 13));
      run_op(op, pick(), pick(), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
